tick_timer: RTL and testbench
=============================

Name: tick_timer

Overview:
- Programmable countdown timer that sits directly downstream of the 4-bit LS163 prescaler counter.
- Consumes the prescaler's rco as a one-cycle "tick" enable, loads a start value, and decrements once per tick.
- Signals expiry with a single-cycle pulse. Used for second and sub-second timing in lab FSMs (e.g. blink, alarm delay).

Parameters:
- WIDTH, 8, bit width of value and remaining count.

Ports:
- clk  input  1  system clock, all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- tick_in  input  1  count enable from prescaler rco; each high cycle is one tick.
- start  input  1  load value and begin counting; single-cycle strobe.
- stop  input  1  abort a running count without expiry.
- value  input  WIDTH  number of ticks to time; sampled only when start=1.
- busy  output  1  high while RUNNING.
- expired  output  1  one-clk-cycle pulse at end of count.
- remaining  output  WIDTH  current count value.

Behaviour:
- One clock (clk). Reset is synchronous and active-high, sampled on posedge clk.
- Reset results after the edge: state=IDLE, remaining=0, busy=0, expired=0, stored reload value=0.
- All outputs are registered; no combinational input-to-output paths.
- States: IDLE, RUNNING, EXPIRED.
- Priority per edge: reset > start > stop > tick_in.
- IDLE:
  - start=1 with value!=0: remaining<=value, state<=RUNNING, busy=1 after that edge.
  - start=1 with value==0: state<=EXPIRED directly; remaining stays 0; busy stays 0.
  - tick_in and stop are ignored.
- RUNNING:
  - start=1 restarts: remaining<=value, or EXPIRED if value==0. The tick on the same cycle is ignored.
  - stop=1: state<=IDLE, remaining<=0, busy<=0, no expired pulse.
  - tick_in=1 with remaining>1: remaining<=remaining-1.
  - tick_in=1 with remaining==1: remaining<=0, state<=EXPIRED.
  - tick_in=0: hold.
- EXPIRED:
  - expired=1, busy=0 for exactly one cycle, then IDLE.
  - start=1 during EXPIRED is honoured as in IDLE: the next state is RUNNING, and the expired pulse still lasts its full cycle.
- Latency:
  - start to busy: 1 edge.
  - Last tick edge to expired high: 1 edge.
  - With tick_in held high, value=N gives expired high N+1 cycles after the start edge.
- Arithmetic is unsigned, WIDTH bits. No wrap: remaining never decrements below 0.
- tick_in held high for multiple cycles counts once per cycle. No edge detection; the prescaler rco is already one cycle wide.
- Reset mid-count aborts immediately with no expired pulse.

Optional Feature:
- Macro: TICK_TIMER_AUTO_RELOAD_EN.
- With the macro defined:
  - value is latched into a reload register on start.
  - On the tick that takes remaining from 1 to 0, remaining<=reload and the state stays RUNNING; busy stays 1.
  - expired pulses for one cycle, driven registered alongside the reload, giving a periodic timer.
  - stop is the only exit; reload==0 behaves as non-auto.
- Without the macro: one-shot behaviour as above. No reload register is synthesized.

Decomposition:
- Shared package tick_timer_pkg:
  - state enum (IDLE, RUNNING, EXPIRED), 2-bit encoding.
  - default WIDTH constant.
- One natural sub-module, tt_downcount: WIDTH-bit loadable down-counter with load, dec, clr and an is_one flag. The FSM in tick_timer drives it.

Test Plan:
- Reset held 2 cycles mid-count at remaining=5 -> after release: remaining=0, busy=0, expired never pulses.
- start with value=3, tick_in high every cycle -> remaining 3,2,1,0 on successive edges; expired=1 for exactly one cycle, 4 cycles after start; then busy=0.
- start with value=2, tick_in pulsed every 16th cycle (driven from LS163 rco) -> expired occurs the cycle after the 2nd rco pulse; remaining holds between ticks.
- start with value=0 -> no busy; expired=1 on the cycle after start; remaining=0.
- Running at remaining=4: assert start (value=9) and tick_in simultaneously -> remaining=9, no decrement. Then assert stop -> IDLE, remaining=0, no expired pulse.
- With TICK_TIMER_AUTO_RELOAD_EN, value=2, tick_in continuous -> expired pulses every 2 cycles, busy stays 1, remaining cycles 2,1,2,1; stop returns to IDLE.

Source files
------------

// File: rtl/tick_timer_pkg.sv
// tick_timer_pkg -- shared types and constants for the tick_timer block.
//   tt_state_e        : controller state encoding (2 bits)
//   TT_WIDTH_DEFAULT  : default width of value / remaining
package tick_timer_pkg;

  localparam int TT_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_EXPIRED = 2'd2
  } tt_state_e;

endpackage

// File: rtl/tick_timer_if.sv
// tick_timer_if -- control/status bundle of the tick_timer.
//   tick_in   : count enable (prescaler rco), one tick per high cycle
//   start     : load value and begin counting (strobe)
//   stop      : abort a running count without expiry
//   value     : number of ticks to time, sampled with start
//   busy      : high while the count is running
//   expired   : one-cycle pulse at end of count
//   remaining : current count value
// Modports: master drives the controls (user side), slave is the timer.
interface tick_timer_if
  import tick_timer_pkg::*;
#(
  parameter int WIDTH = TT_WIDTH_DEFAULT
);
  logic             tick_in;
  logic             start;
  logic             stop;
  logic [WIDTH-1:0] value;
  logic             busy;
  logic             expired;
  logic [WIDTH-1:0] remaining;

  modport master (
    output tick_in, start, stop, value,
    input  busy, expired, remaining
  );

  modport slave (
    input  tick_in, start, stop, value,
    output busy, expired, remaining
  );
endinterface

// File: rtl/tt_downcount.sv
// tt_downcount -- WIDTH-bit loadable down-counter driven by the tick_timer FSM.
//   clk      : clock, posedge
//   clr      : synchronous clear to zero (highest priority)
//   load     : load load_val
//   load_val : value to load
//   dec      : decrement by one, saturating at zero
//   count    : current count
//   is_one   : count == 1, i.e. the next decrement reaches zero
module tt_downcount
  import tick_timer_pkg::*;
#(
  parameter int WIDTH = TT_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             is_one
);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      // Never wraps below zero.
      count <= count - WIDTH'(1);
    end
  end

  assign is_one = (count == WIDTH'(1));

endmodule

// File: rtl/tick_timer.sv
// tick_timer -- programmable countdown timer fed by a prescaler rco tick.
//   clk   : system clock, posedge
//   reset : synchronous, active-high
//   bus   : tick_timer_if.slave (tick_in, start, stop, value in;
//           busy, expired, remaining out)
// Priority per edge: reset > start > stop > tick_in.
// Optional build macro TICK_TIMER_AUTO_RELOAD_EN: periodic mode, the value
// latched at start is reloaded on expiry and the timer keeps running.
module tick_timer
  import tick_timer_pkg::*;
#(
  parameter int WIDTH = TT_WIDTH_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  tick_timer_if.slave  bus
);

  tt_state_e        state;
  tt_state_e        next_state;
  logic             cnt_clr;
  logic             cnt_load;
  logic [WIDTH-1:0] cnt_val;
  logic             cnt_dec;
  logic [WIDTH-1:0] count;
  logic             is_one;

`ifdef TICK_TIMER_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_q;
  logic             reload_hit_d;
  logic             reload_hit_q;
`endif

  tt_downcount #(.WIDTH(WIDTH)) u_cnt (
    .clk      (clk),
    .clr      (cnt_clr),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .count    (count),
    .is_one   (is_one)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

`ifdef TICK_TIMER_AUTO_RELOAD_EN
  // Reload value and the registered expiry pulse of a periodic wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      reload_q     <= '0;
      reload_hit_q <= 1'b0;
    end else begin
      if (bus.start) begin
        reload_q <= bus.value;
      end
      reload_hit_q <= reload_hit_d;
    end
  end
`endif

  // Next-state and counter control
  always_comb begin
    next_state = state;
    cnt_clr    = reset;
    cnt_load   = 1'b0;
    cnt_val    = bus.value;
    cnt_dec    = 1'b0;
`ifdef TICK_TIMER_AUTO_RELOAD_EN
    reload_hit_d = 1'b0;
`endif
    if (!reset) begin
      case (state)
        // EXPIRED accepts start exactly like IDLE; the pulse still lasts
        // its full cycle because it is decoded from the current state.
        ST_IDLE, ST_EXPIRED: begin
          next_state = ST_IDLE;
          if (bus.start) begin
            cnt_load   = 1'b1;
            next_state = (bus.value == '0) ? ST_EXPIRED : ST_RUNNING;
          end
        end
        ST_RUNNING: begin
          if (bus.start) begin
            cnt_load   = 1'b1;
            next_state = (bus.value == '0) ? ST_EXPIRED : ST_RUNNING;
          end else if (bus.stop) begin
            cnt_clr    = 1'b1;
            next_state = ST_IDLE;
          end else if (bus.tick_in) begin
            if (is_one) begin
`ifdef TICK_TIMER_AUTO_RELOAD_EN
              if (reload_q != '0) begin
                cnt_load     = 1'b1;
                cnt_val      = reload_q;
                reload_hit_d = 1'b1;
              end else begin
                cnt_dec    = 1'b1;
                next_state = ST_EXPIRED;
              end
`else
              cnt_dec    = 1'b1;
              next_state = ST_EXPIRED;
`endif
            end else begin
              cnt_dec = 1'b1;
            end
          end
        end
        default: begin
          cnt_clr    = 1'b1;
          next_state = ST_IDLE;
        end
      endcase
    end
  end

  // Outputs, decoded from registers only
  always_comb begin
    bus.busy      = (state == ST_RUNNING);
`ifdef TICK_TIMER_AUTO_RELOAD_EN
    bus.expired   = (state == ST_EXPIRED) || reload_hit_q;
`else
    bus.expired   = (state == ST_EXPIRED);
`endif
    bus.remaining = count;
  end

endmodule

// File: tb/tb_tick_timer.sv
// tb_tick_timer -- directed self-checking bench for tick_timer.
// Inputs change #1 after a rising edge; outputs are sampled at the same
// point, i.e. they show the state produced by that edge.
module tb_tick_timer;
  import tick_timer_pkg::*;

  localparam int WIDTH = 8;

  logic clk;
  logic reset;
  int   checks;
  int   pass_cnt;
  int   fail_cnt;

  tick_timer_if #(.WIDTH(WIDTH)) tif ();

  tick_timer #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (tif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [31:0] rem,
                           input logic b, input logic e);
    check({tag, ".remaining"}, 32'(tif.remaining), rem);
    check({tag, ".busy"},      32'(tif.busy),      32'(b));
    check({tag, ".expired"},   32'(tif.expired),   32'(e));
  endtask

  initial begin
    checks   = 0;
    pass_cnt = 0;
    fail_cnt = 0;
    reset       = 1'b1;
    tif.tick_in = 1'b0;
    tif.start   = 1'b0;
    tif.stop    = 1'b0;
    tif.value   = '0;

    // Reset state
    edge_step();
    edge_step();
    check_out("reset", 0, 1'b0, 1'b0);
    reset = 1'b0;

    // Ticks and stop ignored in IDLE
    tif.tick_in = 1'b1;
    tif.stop    = 1'b1;
    edge_step();
    check_out("idle_ignore", 0, 1'b0, 1'b0);
    tif.stop    = 1'b0;
    tif.tick_in = 1'b0;

    // value=3, tick held high: 3,2,1,0 then one expired cycle
    tif.start   = 1'b1;
    tif.value   = 8'd3;
    tif.tick_in = 1'b1;
    edge_step();
    tif.start = 1'b0;
    check_out("v3_e1", 3, 1'b1, 1'b0);
    edge_step();
    check_out("v3_e2", 2, 1'b1, 1'b0);
    edge_step();
    check_out("v3_e3", 1, 1'b1, 1'b0);
    edge_step();
    check_out("v3_e4", 0, 1'b0, 1'b1);
    edge_step();
    check_out("v3_e5", 0, 1'b0, 1'b0);
    tif.tick_in = 1'b0;

    // value=0: straight to EXPIRED, no busy
    tif.start = 1'b1;
    tif.value = 8'd0;
    edge_step();
    tif.start = 1'b0;
    check_out("v0_e1", 0, 1'b0, 1'b1);
    edge_step();
    check_out("v0_e2", 0, 1'b0, 1'b0);

    // Restart at remaining=4 with a simultaneous tick, then stop
    tif.start = 1'b1;
    tif.value = 8'd6;
    edge_step();
    tif.start = 1'b0;
    check_out("rs_load", 6, 1'b1, 1'b0);
    tif.tick_in = 1'b1;
    edge_step();
    edge_step();
    check_out("rs_at4", 4, 1'b1, 1'b0);
    tif.start = 1'b1;
    tif.value = 8'd9;
    edge_step();
    tif.start = 1'b0;
    check_out("rs_restart", 9, 1'b1, 1'b0);
    tif.stop = 1'b1;
    edge_step();
    tif.stop = 1'b0;
    check_out("rs_stop", 0, 1'b0, 1'b0);
    edge_step();
    check_out("rs_after", 0, 1'b0, 1'b0);
    tif.tick_in = 1'b0;

    // Reset held two cycles mid-count at remaining=5
    tif.start = 1'b1;
    tif.value = 8'd5;
    edge_step();
    tif.start = 1'b0;
    check_out("mr_load", 5, 1'b1, 1'b0);
    reset       = 1'b1;
    tif.tick_in = 1'b1;
    edge_step();
    check_out("mr_r1", 0, 1'b0, 1'b0);
    edge_step();
    check_out("mr_r2", 0, 1'b0, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      edge_step();
      check_out("mr_post", 0, 1'b0, 1'b0);
    end
    tif.tick_in = 1'b0;

    // Start during EXPIRED: pulse completes, then RUNNING with new value
    tif.start   = 1'b1;
    tif.value   = 8'd1;
    tif.tick_in = 1'b1;
    edge_step();
    tif.start = 1'b0;
    check_out("ex_load", 1, 1'b1, 1'b0);
    edge_step();
    check_out("ex_exp", 0, 1'b0, 1'b1);
    tif.tick_in = 1'b0;
    tif.start   = 1'b1;
    tif.value   = 8'd2;
    edge_step();
    tif.start = 1'b0;
    check_out("ex_restart", 2, 1'b1, 1'b0);
    tif.stop = 1'b1;
    edge_step();
    tif.stop = 1'b0;
    check_out("ex_stop", 0, 1'b0, 1'b0);

    // value=2 with a prescaler rco every 16th cycle
    tif.start = 1'b1;
    tif.value = 8'd2;
    edge_step();
    tif.start = 1'b0;
    check_out("ps_load", 2, 1'b1, 1'b0);
    for (int i = 0; i < 40; i++) begin
      logic [3:0] ps;
      ps = 4'(i);
      tif.tick_in = (ps == 4'hF);
      edge_step();
      check_out("ps_run", (i < 15) ? 2 : ((i < 31) ? 1 : 0), (i < 31), (i == 31));
    end
    tif.tick_in = 1'b0;

`ifdef TICK_TIMER_AUTO_RELOAD_EN
    // Periodic mode: remaining 2,1,2,1 with a pulse at each reload
    tif.start   = 1'b1;
    tif.value   = 8'd2;
    tif.tick_in = 1'b1;
    edge_step();
    tif.start = 1'b0;
    check_out("ar_e1", 2, 1'b1, 1'b0);
    edge_step();
    check_out("ar_e2", 1, 1'b1, 1'b0);
    edge_step();
    check_out("ar_e3", 2, 1'b1, 1'b1);
    edge_step();
    check_out("ar_e4", 1, 1'b1, 1'b0);
    edge_step();
    check_out("ar_e5", 2, 1'b1, 1'b1);
    tif.stop = 1'b1;
    edge_step();
    tif.stop = 1'b0;
    check_out("ar_stop", 0, 1'b0, 1'b0);
    tif.tick_in = 1'b0;
`endif

    $display("%0d/%0d checks passed", pass_cnt, checks);
    $finish;
  end

endmodule
